// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the shared double-precision add/sub datapath.
package fp_pkg;
  localparam int unsigned FP_W = 64;
  localparam logic [FP_W-1:0] FP_QNAN    = 64'h7FF8000000000001;
  localparam logic [FP_W-1:0] FP_POS_ONE = 64'h3FF0000000000000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/fp_add_sub.sv
// Combinational IEEE 754 double add/sub, round-to-nearest-even, subnormals supported.
module fp_add_sub
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic            is_sub_i,
  output logic [FP_W-1:0] res_o
);
  logic        sa, sb, sl, eff_sub, a_nan, b_nan, a_inf, b_inf, swap, sticky, up;
  logic [62:0] xl, xs;
  logic [12:0] el, es, d, e;
  logic [55:0] ml, ms, msh, norm;
  logic [56:0] sum;
  logic [53:0] mant;
  int          lz, sh;

  always_comb begin
    sa      = a_i[63];
    sb      = b_i[63] ^ is_sub_i;
    a_nan   = (&a_i[62:52]) & (|a_i[51:0]);
    b_nan   = (&b_i[62:52]) & (|b_i[51:0]);
    a_inf   = (&a_i[62:52]) & ~(|a_i[51:0]);
    b_inf   = (&b_i[62:52]) & ~(|b_i[51:0]);
    eff_sub = sa ^ sb;
    swap    = b_i[62:0] > a_i[62:0];
    sl      = swap ? sb : sa;
    xl      = swap ? b_i[62:0] : a_i[62:0];
    xs      = swap ? a_i[62:0] : b_i[62:0];
    el      = (xl[62:52] == 11'd0) ? 13'd1 : {2'b00, xl[62:52]};
    es      = (xs[62:52] == 11'd0) ? 13'd1 : {2'b00, xs[62:52]};
    ml      = {|xl[62:52], xl[51:0], 3'b000};
    ms      = {|xs[62:52], xs[51:0], 3'b000};
    d       = el - es;
    msh     = '0;
    sticky  = 1'b0;
    if (d >= 13'd56) begin
      sticky = |ms;
    end else begin
      msh    = ms >> d;
      sticky = |(ms & ~({56{1'b1}} << d));
    end
    msh[0] = msh[0] | sticky;
    sum    = eff_sub ? ({1'b0, ml} - {1'b0, msh}) : ({1'b0, ml} + {1'b0, msh});

    lz = 56;
    for (int i = 0; i < 56; i++) begin
      if (sum[i]) lz = 55 - i;
    end
    sh   = 0;
    norm = '0;
    e    = el;
    if (sum[56]) begin
      norm = {sum[56:2], sum[1] | sum[0]};
      e    = el + 13'd1;
    end else begin
      // Stop normalising at the minimum exponent; what remains is subnormal.
      sh   = (lz > int'(el) - 1) ? int'(el) - 1 : lz;
      norm = sum[55:0] << sh;
      e    = el - 13'(sh);
    end

    up   = norm[2] & ((|norm[1:0]) | norm[3]);
    mant = {1'b0, norm[55:3]} + {53'd0, up};
    if (mant[53]) begin
      mant = mant >> 1;
      e    = e + 13'd1;
    end

    if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) begin
      res_o = FP_QNAN;
    end else if (a_inf | b_inf) begin
      res_o = {a_inf ? sa : sb, 11'h7FF, 52'd0};
    end else if (sum == 57'd0) begin
      res_o = {sl & ~eff_sub, 63'd0};
    end else if (mant[52] && e >= 13'd2047) begin
      res_o = {sl, 11'h7FF, 52'd0};
    end else begin
      res_o = {sl, mant[52] ? e[10:0] : 11'd0, mant[51:0]};
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_onehot_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);
  int idx;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_o          = |req_i;
    idx            = 0;
    // Scan from farthest to nearest so the request closest to ptr_i wins.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % int'(N);
      if (req_i[idx]) begin
        grant_onehot_o      = '0;
        grant_onehot_o[idx] = 1'b1;
        grant_idx_o         = IdxW'(idx);
      end
    end
  end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin sharing of one fp_add_sub among NUM_REQ requesters; registered operands and
// result, responses tagged with the issuing requester's index.
module fp_addsub_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  input  logic [FP_W*NUM_REQ-1:0] req_a_in,
  input  logic [FP_W*NUM_REQ-1:0] req_b_in,
  input  logic [NUM_REQ-1:0]      req_is_sub_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [ID_W-1:0]         rsp_id_out,
  output logic [FP_W-1:0]         rsp_res_out,
  output logic                    busy_out,
  output logic [31:0]             ops_count_out
);
  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q, id_q, rsp_id_q;
  logic [FP_W-1:0] a_q, b_q, rsp_res_q, fp_res;
  logic            sub_q, rsp_valid_q;
  logic [31:0]     ops_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req_i         (req_valid_in),
    .ptr_i         (rr_ptr_q),
    .grant_onehot_o(grant_oh),
    .grant_idx_o   (grant_idx),
    .any_o         (grant_any)
  );

  fp_add_sub u_fp (
    .a_i     (a_q),
    .b_i     (b_q),
    .is_sub_i(sub_q),
    .res_o   (fp_res)
  );

  // Ready is held low while reset is asserted so nothing looks accepted during reset.
  assign req_ready_out = (state_q == IDLE && !rst) ? grant_oh : '0;
  assign busy_out      = (state_q != IDLE);
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_id_out    = rsp_id_q;
  assign rsp_res_out   = rsp_res_q;
  assign ops_count_out = ops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      ops_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q      <= req_a_in[FP_W*grant_idx +: FP_W];
            b_q      <= req_b_in[FP_W*grant_idx +: FP_W];
            sub_q    <= req_is_sub_in[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_res_q   <= fp_res;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            ops_q       <= ops_q + 32'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
